// File: rtl/glove_region_detector.sv
// rtl/glove_region_detector.sv - glove region detector with threshold and frame hysteresis
//
// Purpose: counts glove-coloured pixels in four vertical regions of the frame.
//          At each frame end it picks the dominant region, then applies a
//          match threshold and stable/loss frame-count hysteresis before it
//          publishes the highlighted region.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   x_pos        in   [9:0] pixel column
//   y_pos        in   [9:0] pixel row
//   pixel_valid  in   x_pos/y_pos/pixel_match valid this cycle
//   pixel_match  in   pixel classified as glove colour
//   flag         out  glove present in region starting at reg_min
//   reg_min      out  [9:0] left x of highlighted region
//   region_idx   out  [1:0] index of highlighted region
//   frame_done   out  one-cycle pulse when a frame's result is committed
module glove_region_detector #(
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int REGION_W      = 160,
   parameter int THRESHOLD     = 2000,
   parameter int STABLE_FRAMES = 3,
   parameter int LOSS_FRAMES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic       pixel_valid,
   input  logic       pixel_match,
   output logic       flag,
   output logic [9:0] reg_min,
   output logic [1:0] region_idx,
   output logic       frame_done
);

   localparam logic [9:0]  LP_H_ACTIVE = 10'(H_ACTIVE);
   localparam logic [9:0]  LP_V_ACTIVE = 10'(V_ACTIVE);
   localparam logic [9:0]  LP_REGION_W = 10'(REGION_W);
   localparam logic [16:0] LP_THRESH   = 17'(THRESHOLD);
   localparam logic [2:0]  LP_STABLE   = 3'(STABLE_FRAMES);
   localparam logic [2:0]  LP_LOSS     = 3'(LOSS_FRAMES);

   logic [16:0] r_cnt  [4];
   logic [16:0] r_snap [4];
   logic        r_s1_go;
   logic        r_s2_go;
   logic [1:0]  r_winner;
   logic        r_win_valid;
   logic [1:0]  r_cand;
   logic        r_cand_valid;
   logic [2:0]  r_stable_cnt;
   logic [2:0]  r_miss_cnt;
   logic        r_flag;
   logic [9:0]  r_reg_min;
   logic [1:0]  r_region_idx;
   logic        r_frame_done;

   logic        w_count;
   logic        w_frame_end;
   logic [1:0]  w_region;
   logic [1:0]  w_best_idx;
   logic [16:0] w_best_val;
   logic        w_same;
   logic [2:0]  w_stable_nxt;
   logic [2:0]  w_miss_nxt;
   logic [9:0]  w_reg_min;

   assign w_count     = pixel_valid && pixel_match &&
                        (x_pos < LP_H_ACTIVE) && (y_pos < LP_V_ACTIVE);
   assign w_frame_end = pixel_valid && (x_pos == LP_H_ACTIVE - 10'd1) &&
                        (y_pos == LP_V_ACTIVE - 10'd1);

   always_comb begin
      w_region = 2'd3;
      if (x_pos < LP_REGION_W)
         w_region = 2'd0;
      else if (x_pos < LP_REGION_W * 10'd2)
         w_region = 2'd1;
      else if (x_pos < LP_REGION_W * 10'd3)
         w_region = 2'd2;
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      w_best_idx = 2'd0;
      w_best_val = r_snap[0];
      for (int i = 1; i < 4; i++) begin
         if (r_snap[i] > w_best_val) begin
            w_best_idx = 2'(i);
            w_best_val = r_snap[i];
         end
      end
   end

   // Next candidate state for the commit stage.
   assign w_same = r_win_valid && r_cand_valid && (r_winner == r_cand);

   always_comb begin
      w_stable_nxt = 3'd0;
      w_miss_nxt   = 3'd0;
      if (r_win_valid) begin
         if (w_same)
            w_stable_nxt = (r_stable_cnt == 3'd7) ? 3'd7 : r_stable_cnt + 3'd1;
         else
            w_stable_nxt = 3'd1;
      end else begin
         w_miss_nxt = (r_miss_cnt == 3'd7) ? 3'd7 : r_miss_cnt + 3'd1;
      end
   end

   assign w_reg_min = LP_REGION_W * {8'd0, r_winner};

   // Live counters and the frame-end snapshot; the frame-end pixel itself
   // is folded into the snapshot and the live counters restart from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_cnt[i]  <= '0;
            r_snap[i] <= '0;
         end
         r_s1_go <= 1'b0;
         r_s2_go <= 1'b0;
      end else begin
         r_s1_go <= w_frame_end;
         r_s2_go <= r_s1_go;
         for (int i = 0; i < 4; i++) begin
            if (w_frame_end) begin
               r_cnt[i] <= '0;
               if (w_count && (w_region == 2'(i)) && (r_cnt[i] != '1))
                  r_snap[i] <= r_cnt[i] + 17'd1;
               else
                  r_snap[i] <= r_cnt[i];
            end else if (w_count && (w_region == 2'(i)) && (r_cnt[i] != '1)) begin
               r_cnt[i] <= r_cnt[i] + 17'd1;
            end
         end
      end
   end

   // Stage 1 picks the winner, stage 2 applies the hysteresis.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_winner     <= 2'd0;
         r_win_valid  <= 1'b0;
         r_cand       <= 2'd0;
         r_cand_valid <= 1'b0;
         r_stable_cnt <= 3'd0;
         r_miss_cnt   <= 3'd0;
         r_flag       <= 1'b0;
         r_reg_min    <= 10'd0;
         r_region_idx <= 2'd0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= r_s2_go;
         if (r_s1_go) begin
            r_winner    <= w_best_idx;
            r_win_valid <= (w_best_val >= LP_THRESH);
         end
         if (r_s2_go) begin
            r_stable_cnt <= w_stable_nxt;
            r_miss_cnt   <= w_miss_nxt;
            if (r_win_valid) begin
               r_cand       <= r_winner;
               r_cand_valid <= 1'b1;
               if (w_stable_nxt >= LP_STABLE) begin
                  r_flag       <= 1'b1;
                  r_region_idx <= r_winner;
                  r_reg_min    <= w_reg_min;
               end
            end else begin
               r_cand_valid <= 1'b0;
               // Region outputs hold so the last highlight position survives.
               if (w_miss_nxt >= LP_LOSS)
                  r_flag <= 1'b0;
            end
         end
      end
   end

   assign flag       = r_flag;
   assign reg_min    = r_reg_min;
   assign region_idx = r_region_idx;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_glove_region_detector.sv
// tb/tb_glove_region_detector.sv - self-checking bench for glove_region_detector
module tb_glove_region_detector;

   localparam int SAT = 131071;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] x_pos = '0;
   logic [9:0] y_pos = '0;
   logic       pixel_valid = 1'b0;
   logic       pixel_match = 1'b0;
   logic       flag;
   logic [9:0] reg_min;
   logic [1:0] region_idx;
   logic       frame_done;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int m_cnt  [4];
   int m_snap [4];
   int m_pend;
   int m_cand;
   int m_cand_v;
   int m_stab;
   int m_miss;
   int e_flag;
   int e_reg;
   int e_idx;
   int e_fd;

   glove_region_detector dut (
      .clk         (clk),
      .reset       (reset),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .pixel_valid (pixel_valid),
      .pixel_match (pixel_match),
      .flag        (flag),
      .reg_min     (reg_min),
      .region_idx  (region_idx),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i]  = 0;
         m_snap[i] = 0;
      end
      m_pend = 0; m_cand = 0; m_cand_v = 0; m_stab = 0; m_miss = 0;
      e_flag = 0; e_reg = 0; e_idx = 0; e_fd = 0;
   endtask

   task automatic model_commit();
      int best;
      best = 0;
      for (int i = 1; i < 4; i++)
         if (m_snap[i] > m_snap[best]) best = i;
      if (m_snap[best] >= 2000) begin
         if (m_cand_v != 0 && best == m_cand) begin
            m_stab = (m_stab + 1 > 7) ? 7 : m_stab + 1;
         end else begin
            m_cand = best; m_cand_v = 1; m_stab = 1;
         end
         m_miss = 0;
         if (m_stab >= 3) begin
            e_flag = 1; e_idx = m_cand; e_reg = m_cand * 160;
         end
      end else begin
         m_cand_v = 0; m_stab = 0;
         m_miss = (m_miss + 1 > 7) ? 7 : m_miss + 1;
         if (m_miss >= 2) e_flag = 0;
      end
   endtask

   // Behavioural model: per-frame region counts, result appears two edges
   // after the frame-end pixel.
   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            model_clear();
         end else begin
            e_fd = 0;
            if (m_pend > 0) begin
               m_pend--;
               if (m_pend == 0) begin
                  model_commit();
                  e_fd = 1;
               end
            end
            if (pixel_valid && pixel_match && x_pos < 640 && y_pos < 480)
               m_cnt[x_pos / 160] = (m_cnt[x_pos / 160] + 1 > SAT) ? SAT : m_cnt[x_pos / 160] + 1;
            if (pixel_valid && x_pos == 639 && y_pos == 479) begin
               for (int i = 0; i < 4; i++) begin
                  m_snap[i] = m_cnt[i];
                  m_cnt[i]  = 0;
               end
               m_pend = 2;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("flag", int'(flag), e_flag);
         chk("reg_min", int'(reg_min), e_reg);
         chk("region_idx", int'(region_idx), e_idx);
         chk("frame_done", int'(frame_done), e_fd);
      end
   end

   task automatic run(input int x_lo, input int x_hi, input int y_base, input bit m, input int n);
      int w;
      w = x_hi - x_lo + 1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         pixel_valid = 1'b1;
         pixel_match = m;
         x_pos = 10'(x_lo + i % w);
         y_pos = 10'(y_base + (i / w) % 400);
      end
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      pixel_match = 1'b0;
   endtask

   task automatic frame_end(input bit m);
      int k;
      @(posedge clk); #1;
      pixel_valid = 1'b1;
      pixel_match = m;
      x_pos = 10'd639;
      y_pos = 10'd479;
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      pixel_match = 1'b0;
      k = 0;
      while (k < 10 && !frame_done) begin
         @(posedge clk); #1;
         k++;
      end
      chk("fd_latency", k, 2);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic lit(input int f, input int r, input int idx);
      chk("lit_flag", int'(flag), f);
      chk("lit_reg_min", int'(reg_min), r);
      chk("lit_region_idx", int'(region_idx), idx);
   endtask

   initial begin
      #23;
      lit(0, 0, 0);
      chk("reset_fd", int'(frame_done), 0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      lit(0, 0, 0);

      // three frames, region 1
      for (int f = 0; f < 3; f++) begin
         run(170, 300, 0, 1'b1, 3000);
         frame_end(1'b0);
         if (f < 2) lit(0, 0, 0);
      end
      lit(1, 160, 1);

      // two frames just below threshold in every region
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < 4; r++)
            run(r * 160, r * 160 + 150, 0, 1'b1, 1999);
         frame_end(1'b0);
         if (f == 0) lit(1, 160, 1);
      end
      lit(0, 160, 1);

      // exactly threshold in region 3, frame-end pixel included
      run(490, 630, 0, 1'b1, 1999);
      frame_end(1'b1);
      lit(0, 160, 1);

      // relock region 1, then switch to region 3
      for (int f = 0; f < 3; f++) begin
         run(170, 300, 0, 1'b1, 2100);
         frame_end(1'b0);
      end
      lit(1, 160, 1);
      for (int f = 0; f < 3; f++) begin
         run(500, 600, 0, 1'b1, 2100);
         frame_end(1'b0);
         if (f < 2) lit(1, 160, 1);
      end
      lit(1, 480, 3);

      // tie between regions 0 and 2, with off-screen matches
      for (int f = 0; f < 3; f++) begin
         run(0, 150, 0, 1'b1, 2500);
         run(330, 470, 0, 1'b1, 2500);
         run(700, 760, 0, 1'b1, 50);
         run(330, 400, 500, 1'b1, 50);
         frame_end(1'b0);
      end
      lit(1, 0, 0);

      // mid-frame async reset
      run(0, 150, 0, 1'b1, 1500);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      lit(0, 0, 0);
      chk("rst_fd", int'(frame_done), 0);
      #13;
      reset = 1'b0;
      run(0, 150, 0, 1'b1, 1000);
      frame_end(1'b0);
      lit(0, 0, 0);

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
